// File: rtl/hazard3_ahb_dport_arbiter_if.sv
// Bundles the requester handshakes and the AHB-Lite master-side bus of hazard3_ahb_dport_arbiter.
// The master modport is the arbiter's view; the slave modport is the view of requesters plus system bus.
interface hazard3_ahb_dport_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  // Handshake: an address phase of requester i is offered while req_vld[i] is high and completes
  // in the cycle req_aph_ready[i] is high. Until then vld and all request fields must stay stable.
  // Its data phase completes in the cycle req_dph_ready[i] is high.
  logic [N_REQ-1:0]        req_vld;
  logic [N_REQ*W_ADDR-1:0] req_addr;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ*3-1:0]      req_size;
  logic [N_REQ-1:0]        req_excl;
  logic [N_REQ-1:0]        req_priv;
  logic [N_REQ*W_DATA-1:0] req_wdata;
  logic [N_REQ-1:0]        req_aph_ready;
  logic [N_REQ-1:0]        req_dph_ready;
  logic [N_REQ-1:0]        req_dph_err;
  logic [N_REQ-1:0]        req_dph_exokay;
  logic [W_DATA-1:0]       req_rdata;

  logic [W_ADDR-1:0]       haddr;
  logic                    hwrite;
  logic [1:0]              htrans;
  logic [2:0]              hsize;
  logic [2:0]              hburst;
  logic [3:0]              hprot;
  logic                    hmastlock;
  logic [7:0]              hmaster;
  logic                    hexcl;
  logic [W_DATA-1:0]       hwdata;
  logic                    hready;
  logic                    hresp;
  logic                    hexokay;
  logic [W_DATA-1:0]       hrdata;

  modport master (
    input  req_vld, req_addr, req_write, req_size, req_excl, req_priv, req_wdata,
    output req_aph_ready, req_dph_ready, req_dph_err, req_dph_exokay, req_rdata,
    output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hmaster, hexcl, hwdata,
    input  hready, hresp, hexokay, hrdata
  );

  modport slave (
    output req_vld, req_addr, req_write, req_size, req_excl, req_priv, req_wdata,
    input  req_aph_ready, req_dph_ready, req_dph_err, req_dph_exokay, req_rdata,
    input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hmaster, hexcl, hwdata,
    output hready, hresp, hexokay, hrdata
  );
endinterface

// File: rtl/hazard3_ahb_dport_arbiter.sv
// N-requester AHB-Lite master-port arbiter for the Hazard3 load/store port (index 0 is the core).
// Define HAZARD3_ARB_ROUND_ROBIN_EN for core-priority round robin; otherwise fixed lowest-index priority.
module hazard3_ahb_dport_arbiter #(
  parameter int         N_REQ          = 2,
  parameter int         W_ADDR         = 32,
  parameter int         W_DATA         = 32,
  parameter logic [7:0] PIPELINED_MASK = 8'h01,
  parameter logic [7:0] HMASTER_BASE   = 8'h00
) (
  input logic clk,
  input logic rst,
  hazard3_ahb_dport_arbiter_if.master bus
);
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;

  logic             hold_aph;
  logic [N_REQ-1:0] gnt_prev;
  logic [N_REQ-1:0] dph_active;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] arb_gnt;
  logic [N_REQ-1:0] gnt;
  logic             gnt_any;
  logic [2:0]       gnt_idx;
  logic             priv_sel;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = bus.req_vld[i] && (PIPELINED_MASK[i] || !dph_active[i]);
    end
  end

`ifdef HAZARD3_ARB_ROUND_ROBIN_EN
  localparam int W_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [W_PTR-1:0] rr_ptr;
  logic [W_PTR-1:0] rr_start;
  logic [W_PTR-1:0] rr_next;

  // rr_ptr of 0 (after reset) behaves like 1: the search only ever covers indices 1..N_REQ-1.
  assign rr_start = (rr_ptr == '0) ? W_PTR'(1) : rr_ptr;

  always_comb begin
    int best;
    int best_rank;
    int rank;
    arb_gnt   = '0;
    best      = -1;
    best_rank = N_REQ;
    rank      = 0;
    for (int i = 1; i < N_REQ; i++) begin
      rank = i - int'(rr_start);
      if (rank < 0) rank = rank + N_REQ - 1;
      if (eligible[i] && rank < best_rank) begin
        best_rank = rank;
        best      = i;
      end
    end
    if (eligible[0]) best = 0;
    for (int i = 0; i < N_REQ; i++) begin
      arb_gnt[i] = (best == i);
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    if (bus.hready && gnt_any && gnt_idx != 3'd0) begin
      rr_next = (int'(gnt_idx) == N_REQ - 1) ? W_PTR'(1) : W_PTR'(int'(gnt_idx) + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr <= '0;
    else     rr_ptr <= rr_next;
  end
`else
  always_comb begin
    arb_gnt = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        arb_gnt    = '0;
        arb_gnt[i] = 1'b1;
      end
    end
  end
`endif

  // Reset is folded in combinationally so the bus goes IDLE the moment rst rises, even mid-stall.
  assign gnt     = rst ? '0 : (hold_aph ? gnt_prev : arb_gnt);
  assign gnt_any = |gnt;

  always_comb begin
    gnt_idx    = 3'd0;
    bus.haddr  = '0;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'd0;
    bus.hexcl  = 1'b0;
    priv_sel   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx    = 3'(i);
        bus.haddr  = bus.req_addr[i*W_ADDR +: W_ADDR];
        bus.hwrite = bus.req_write[i];
        bus.hsize  = bus.req_size[i*3 +: 3];
        bus.hexcl  = bus.req_excl[i];
        priv_sel   = bus.req_priv[i];
      end
    end
  end

  always_comb begin
    bus.hwdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (dph_active[i]) bus.hwdata = bus.req_wdata[i*W_DATA +: W_DATA];
    end
  end

  assign bus.htrans         = gnt_any ? HTRANS_NSEQ : HTRANS_IDLE;
  assign bus.hburst         = 3'd0;
  assign bus.hmastlock      = 1'b0;
  assign bus.hprot          = {2'b00, priv_sel | (gnt_idx != 3'd0), 1'b1};
  assign bus.hmaster        = HMASTER_BASE + {5'd0, gnt_idx};
  assign bus.req_aph_ready  = bus.hready ? gnt : '0;
  assign bus.req_dph_ready  = bus.hready ? dph_active : '0;
  assign bus.req_dph_err    = bus.hresp ? dph_active : '0;
  assign bus.req_dph_exokay = bus.hexokay ? dph_active : '0;
  assign bus.req_rdata      = bus.hrdata;

  // A stalled NSEQ keeps its owner; the first error cycle releases it so the aph may be withdrawn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_aph   <= 1'b0;
      gnt_prev   <= '0;
      dph_active <= '0;
    end else begin
      hold_aph <= gnt_any && !bus.hready && !bus.hresp;
      gnt_prev <= gnt;
      if (bus.hready) dph_active <= gnt;
    end
  end
endmodule

// File: tb/tb_hazard3_ahb_dport_arbiter.sv
// Bench for hazard3_ahb_dport_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against an owner-index model of the arbiter.
module tb_hazard3_ahb_dport_arbiter;
  localparam int         N      = 3;
  localparam int         W_ADDR = 32;
  localparam int         W_DATA = 32;
  localparam logic [7:0] PIPE   = 8'h03;
  localparam logic [7:0] BASE   = 8'h10;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  hazard3_ahb_dport_arbiter_if #(.N_REQ(N), .W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

  hazard3_ahb_dport_arbiter #(
    .N_REQ(N), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .PIPELINED_MASK(PIPE), .HMASTER_BASE(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic              r_vld[N];
  logic [W_ADDR-1:0] r_addr[N];
  logic              r_write[N];
  logic [2:0]        r_size[N];
  logic              r_excl[N];
  logic              r_priv[N];
  logic [W_DATA-1:0] r_wdata[N];

  // Model state: owner of a held address phase, owner of the data phase (-1 = none), rr pointer.
  int m_held = -1;
  int m_dph  = -1;
  int m_rr   = 0;
  bit m_acc[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit elig(input int i);
    return r_vld[i] && (PIPE[i] || m_dph != i);
  endfunction

  function automatic int model_pick();
    if (rst) return -1;
    if (m_held >= 0) return m_held;
`ifdef HAZARD3_ARB_ROUND_ROBIN_EN
    begin
      int start;
      if (elig(0)) return 0;
      start = (m_rr == 0) ? 1 : m_rr;
      for (int k = 0; k < N - 1; k++) begin
        int idx;
        idx = 1 + (start - 1 + k) % (N - 1);
        if (elig(idx)) return idx;
      end
    end
`else
    for (int i = 0; i < N; i++) begin
      if (elig(i)) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i, input logic en);
    logic [N-1:0] v;
    v = '0;
    if (en && i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_held = -1;
      m_dph  = -1;
      m_rr   = 0;
      for (int i = 0; i < N; i++) m_acc[i] = 1'b0;
    end else begin
      int g;
      g = model_pick();
      for (int i = 0; i < N; i++) m_acc[i] = bus.hready && (g == i);
      if (bus.hready) m_dph = g;
      m_held = (g >= 0 && !bus.hready && !bus.hresp) ? g : -1;
      if (bus.hready && g >= 1) m_rr = (g == N - 1) ? 1 : g + 1;
    end
  end

  always @(negedge clk) begin
    int g;
    g = model_pick();
    chk("htrans", bus.htrans, (g >= 0) ? 2'b10 : 2'b00);
    chk("aph_ready", bus.req_aph_ready, oh(g, bus.hready));
    chk("dph_ready", bus.req_dph_ready, oh(m_dph, bus.hready));
    chk("dph_err", bus.req_dph_err, oh(m_dph, bus.hresp));
    chk("dph_exokay", bus.req_dph_exokay, oh(m_dph, bus.hexokay));
    chk("rdata", bus.req_rdata, bus.hrdata);
    chk("hmaster", bus.hmaster, BASE + ((g >= 0) ? 8'(g) : 8'd0));
    chk("hburst", bus.hburst, 3'd0);
    chk("hmastlock", bus.hmastlock, 1'b0);
    chk("haddr", bus.haddr, (g >= 0) ? r_addr[g] : '0);
    chk("hwrite", bus.hwrite, (g >= 0) ? r_write[g] : 1'b0);
    chk("hsize", bus.hsize, (g >= 0) ? r_size[g] : 3'd0);
    chk("hexcl", bus.hexcl, (g >= 0) ? r_excl[g] : 1'b0);
    if (g >= 0) chk("hprot", bus.hprot, {2'b00, r_priv[g] | (g != 0), 1'b1});
    if (m_dph >= 0) chk("hwdata", bus.hwdata, r_wdata[m_dph]);
  end

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req_vld[i]                      = r_vld[i];
      bus.req_addr[i*W_ADDR +: W_ADDR]    = r_addr[i];
      bus.req_write[i]                    = r_write[i];
      bus.req_size[i*3 +: 3]              = r_size[i];
      bus.req_excl[i]                     = r_excl[i];
      bus.req_priv[i]                     = r_priv[i];
      bus.req_wdata[i*W_DATA +: W_DATA]   = r_wdata[i];
    end
  endtask

  task automatic set_req(input int i, input logic [W_ADDR-1:0] addr);
    r_vld[i]   = 1'b1;
    r_addr[i]  = addr;
    r_write[i] = addr[12];
    r_size[i]  = 3'd2;
    r_excl[i]  = 1'b0;
    r_priv[i]  = 1'b0;
    r_wdata[i] = ~addr;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) r_vld[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      r_vld[i] = 1'b0; r_addr[i] = '0; r_write[i] = 1'b0; r_size[i] = 3'd0;
      r_excl[i] = 1'b0; r_priv[i] = 1'b0; r_wdata[i] = '0;
    end
    bus.hready = 1'b1; bus.hresp = 1'b0; bus.hexokay = 1'b0; bus.hrdata = '0;
    apply();
    repeat (2) step();
    @(negedge clk);
    chk("rst_htrans", bus.htrans, 2'b00);
    chk("rst_hmaster", bus.hmaster, 8'h10);
    chk("rst_aph_ready", bus.req_aph_ready, 3'b000);
    chk("rst_dph_ready", bus.req_dph_ready, 3'b000);
    step();
    rst = 1'b0;
    step();

    // Single core request on an idle bus: zero-latency grant, dph next cycle.
    set_req(0, 32'h1000); apply();
    @(negedge clk);
    chk("t1_htrans", bus.htrans, 2'b10);
    chk("t1_aph_ready", bus.req_aph_ready, 3'b001);
    chk("t1_hmaster", bus.hmaster, 8'h10);
    step(); clear_reqs(); apply();
    @(negedge clk);
    chk("t1_dph_ready", bus.req_dph_ready, 3'b001);

    // Contention under wait states: req0 owns the stalled aph, req1 follows.
    step(); set_req(0, 32'h2000); set_req(1, 32'h3000); bus.hready = 1'b0; apply();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_haddr_stall", bus.haddr, 32'h2000);
      chk("t2_hmaster_stall", bus.hmaster, 8'h10);
      if (k < 2) step();
    end
    step(); bus.hready = 1'b1; apply();
    @(negedge clk);
    chk("t2_aph_ready0", bus.req_aph_ready, 3'b001);
    step(); r_vld[0] = 1'b0; apply();
    @(negedge clk);
    chk("t2_haddr1", bus.haddr, 32'h3000);
    chk("t2_hmaster1", bus.hmaster, 8'h11);
    chk("t2_aph_ready1", bus.req_aph_ready, 3'b010);

    // Two-cycle error in req1 dph; req0 aph offered in the first cycle, withdrawn in the second.
    step(); r_vld[1] = 1'b0; set_req(0, 32'h4000); bus.hready = 1'b0; bus.hresp = 1'b1; apply();
    @(negedge clk);
    chk("t3_err_c1", bus.req_dph_err, 3'b010);
    chk("t3_dph_ready_c1", bus.req_dph_ready, 3'b000);
    chk("t3_htrans_c1", bus.htrans, 2'b10);
    step(); r_vld[0] = 1'b0; bus.hready = 1'b1; apply();
    @(negedge clk);
    chk("t3_err_c2", bus.req_dph_err, 3'b010);
    chk("t3_dph_ready_c2", bus.req_dph_ready, 3'b010);
    chk("t3_htrans_c2", bus.htrans, 2'b00);

    // Non-pipelined req2 held valid: grant only when its own dph is not active.
    step(); bus.hresp = 1'b0; set_req(2, 32'h5000); apply();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t4_htrans_gap", bus.htrans, (k % 2 == 0) ? 2'b10 : 2'b00);
      step();
    end
    clear_reqs();

    // Async reset in the middle of a stalled aph with a dph outstanding.
    set_req(0, 32'h6000); apply();
    step(); set_req(0, 32'h7000); bus.hready = 1'b0; apply();
    step();
    #2 rst = 1'b1;
    #1;
    chk("t5_htrans_rst", bus.htrans, 2'b00);
    chk("t5_aph_ready_rst", bus.req_aph_ready, 3'b000);
    chk("t5_hmaster_rst", bus.hmaster, 8'h10);
    bus.hready = 1'b1; bus.hresp = 1'b1; apply();
    #1;
    chk("t5_dph_ready_rst", bus.req_dph_ready, 3'b000);
    chk("t5_dph_err_rst", bus.req_dph_err, 3'b000);
    step(); clear_reqs(); bus.hresp = 1'b0; apply(); rst = 1'b0;
    @(negedge clk);
    chk("t5_dph_ready_after", bus.req_dph_ready, 3'b000);

    // Random traffic: requesters hold until accepted; bus inserts waits and two-cycle errors.
    begin
      int err_phase;
      err_phase = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        step();
        for (int i = 0; i < N; i++) begin
          if (!r_vld[i] || m_acc[i]) begin
            r_vld[i]   = ($urandom_range(0, 99) < 55);
            r_addr[i]  = $urandom;
            r_write[i] = 1'($urandom_range(0, 1));
            r_size[i]  = 3'($urandom_range(0, 2));
            r_excl[i]  = 1'($urandom_range(0, 1));
            r_priv[i]  = 1'($urandom_range(0, 1));
          end
          r_wdata[i] = $urandom;
        end
        if (err_phase == 1) begin
          bus.hresp = 1'b1; bus.hready = 1'b1; err_phase = 0;
        end else if (m_dph >= 0 && $urandom_range(0, 99) < 10) begin
          bus.hresp = 1'b1; bus.hready = 1'b0; err_phase = 1;
        end else begin
          bus.hresp = 1'b0; bus.hready = ($urandom_range(0, 99) < 75);
        end
        bus.hexokay = 1'($urandom_range(0, 1));
        bus.hrdata  = $urandom;
        apply();
      end
    end
    step();
    clear_reqs(); apply();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
